// File: rtl/uart_frame_rx.sv
// Framed-packet extractor behind a UART receiver: SYNC, LEN, payload, CHK.
// A payload is buffered and released as a valid/ready stream only after its checksum matches.
module uart_frame_rx #(
  parameter int              DATA      = 8,
  parameter logic [DATA-1:0] SYNC_BYTE = 8'hA5,
  parameter int              MAX_LEN   = 16,
  parameter int              TIMEOUT   = 104160
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DATA-1:0] data_in,
  input  logic            data_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic            overrun,
  output logic            busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [DATA-1:0]  MAX_B  = DATA'(MAX_LEN);
  localparam logic [DATA-1:0]  ONE_B  = DATA'(1);
  localparam logic [IDX_W-1:0] ONE_I  = IDX_W'(1);
  localparam logic [TO_W-1:0]  ONE_T  = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LIM = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {HUNT, LEN_S, PAYLOAD, CHECK, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DATA-1:0]  len_q, sum_q, last_pos;
  logic [IDX_W-1:0] wr_idx, rd_idx, nxt_rd;
  logic [TO_W-1:0]  idle_q;
  logic [DATA-1:0]  mem [MAX_LEN];

  logic       ok_d, err_d, ovr_d, len_ld, pl_wr, drain_ld, xfer, timed, timeout;
  logic [1:0] code_d;

  assign last_pos = len_q - ONE_B;
  assign nxt_rd   = rd_idx + ONE_I;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d  = state_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    code_d   = err_code;
    len_ld   = 1'b0;
    pl_wr    = 1'b0;
    drain_ld = 1'b0;
    xfer     = 1'b0;
    timed    = (state_q == LEN_S) || (state_q == PAYLOAD) || (state_q == CHECK);
    timeout  = timed && !data_ready && (idle_q == TO_LIM);

    case (state_q)
      HUNT: if (data_ready && data_in == SYNC_BYTE) state_d = LEN_S;
      LEN_S: if (data_ready) begin
        if (data_in == '0 || data_in > MAX_B) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = HUNT;
        end else begin
          len_ld  = 1'b1;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (data_ready) begin
        pl_wr = 1'b1;
        if (DATA'(wr_idx) == last_pos) state_d = CHECK;
      end
      CHECK: if (data_ready) begin
        if (data_in == sum_q) begin
          ok_d     = 1'b1;
          drain_ld = 1'b1;
          state_d  = DRAIN;
        end else begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = HUNT;
        end
      end
      DRAIN: begin
        // Bytes arriving while the buffer drains are dropped and reported.
        ovr_d = data_ready;
        xfer  = out_valid && out_ready;
        if (xfer && out_last) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    if (timeout) begin
      err_d   = 1'b1;
      code_d  = 2'd3;
      state_d = HUNT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= HUNT;
    else      state_q <= state_d;
  end

  // NOTE: the payload buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (pl_wr) mem[wr_idx] <= data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      sum_q     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      idle_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Idle counter restarts on any byte and on every state change.
      if (!timed || data_ready || state_d != state_q) idle_q <= '0;
      else                                            idle_q <= idle_q + ONE_T;

      if (len_ld) begin
        len_q  <= data_in;
        sum_q  <= data_in;
        wr_idx <= '0;
      end
      if (pl_wr) begin
        sum_q  <= sum_q + data_in;
        wr_idx <= wr_idx + ONE_I;
      end

      if (drain_ld) begin
        rd_idx    <= '0;
        out_valid <= 1'b1;
        out_data  <= mem[0];
        out_last  <= (len_q == ONE_B);
      end else if (xfer) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          rd_idx   <= nxt_rd;
          out_data <= mem[nxt_rd];
          out_last <= (DATA'(nxt_rd) == last_pos);
        end
      end

      frame_ok  <= ok_d;
      frame_err <= err_d;
      overrun   <= ovr_d;
      err_code  <= code_d;
      busy      <= (state_d != HUNT);
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: a byte-level frame model predicts payload and
// events, and a per-cycle compare process checks the DUT against it.
module tb_uart_frame_rx;

  localparam int          T    = 40;
  localparam int          MAXL = 16;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic       frame_ok, frame_err, overrun, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  uart_frame_rx #(.DATA(8), .SYNC_BYTE(SYNC), .MAX_LEN(MAXL), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_ready(data_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .overrun(overrun), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame model: bytes after SYNC collect in frm (frm[0] is LEN).
  logic [7:0] frm[$];
  bit         in_frame = 0;
  logic [8:0] exp_out[$];     // {last, data}
  int         exp_ev[$];      // 0 = frame ok, 1..3 = error code
  int         exp_ovr = 0;

  function automatic logic [7:0] chk_of(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += frm[i];
    return s[7:0];
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (exp_out.size() > 0) begin
      exp_ovr++;
      return;
    end
    if (!in_frame) begin
      if (b == SYNC) begin
        in_frame = 1;
        frm.delete();
      end
      return;
    end
    frm.push_back(b);
    if (frm.size() == 1 && (b == 8'h00 || int'(b) > MAXL)) begin
      exp_ev.push_back(1);
      in_frame = 0;
    end else if (frm.size() == int'(frm[0]) + 2) begin
      if (b == chk_of(frm.size() - 1)) begin
        exp_ev.push_back(0);
        for (int i = 1; i <= int'(frm[0]); i++)
          exp_out.push_back({(i == int'(frm[0])), frm[i]});
      end else begin
        exp_ev.push_back(2);
      end
      in_frame = 0;
    end
  endtask

  task automatic model_timeout();
    if (in_frame) begin
      exp_ev.push_back(3);
      in_frame = 0;
    end
  endtask

  task automatic model_reset();
    in_frame = 0;
    exp_out.delete();
    exp_ev.delete();
  endtask

  // Compare process, sampling at the falling edge.
  logic [7:0] got[$];
  logic       got_last[$];
  int         ok_cnt = 0, err_cnt = 0, ovr_seen = 0;
  int         last_code = 0;
  bit         stalled = 0;
  logic [7:0] hold_data;
  logic       hold_last;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      last_code = 0;
      stalled   = 0;
    end else begin
      check("ok and err together", frame_ok & frame_err, 0);
      if (frame_ok) begin
        ok_cnt++;
        check("frame_ok event", (exp_ev.size() > 0) ? exp_ev[0] : 99, 0);
        if (exp_ev.size() > 0) void'(exp_ev.pop_front());
        check("out_valid with frame_ok", out_valid, 1);
      end
      if (frame_err) begin
        int e;
        err_cnt++;
        e = (exp_ev.size() > 0) ? exp_ev.pop_front() : 99;
        check("frame_err code", err_code, e);
        if (e != 99) last_code = e;
      end
      check("err_code hold", err_code, last_code);
      if (overrun) ovr_seen++;
      if (out_valid) begin
        if (stalled) begin
          check("stall data", out_data, hold_data);
          check("stall last", out_last, hold_last);
        end
        if (out_ready) begin
          logic [31:0] ev;
          ev = (exp_out.size() > 0) ? {23'b0, exp_out.pop_front()} : 32'hDEAD;
          check("out byte", {out_last, out_data}, ev);
          got.push_back(out_data);
          got_last.push_back(out_last);
        end
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  bit rand_ready = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  logic [7:0] stim[$];
  logic [7:0] want[$];

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in    = b;
    data_ready = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1 data_ready = 1'b0;
  endtask

  task automatic send_stim();
    foreach (stim[i]) send_byte(stim[i]);
    stim.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic settle(input string name);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (exp_out.size() == 0 && exp_ev.size() == 0 && !busy && !out_valid) break;
    end
    check({name, " settled"}, (i < 400), 1);
    check({name, " busy low"}, busy, 0);
  endtask

  task automatic check_got(input string name);
    check({name, " count"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++) begin
      check({name, " data"}, got[i], want[i]);
      check({name, " last"}, got_last[i], (i == want.size() - 1));
    end
    got.delete();
    got_last.delete();
    want.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int k, ok0, err0, ovr0;
    rst = 1'b0; data_in = 8'h00; data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {out_data, out_valid, out_last, frame_ok, frame_err,
                            err_code, overrun, busy}, 0);
    rst = 1'b1;

    // 1: basic frame, plus a byte landing on the last transfer cycle
    ok0 = ok_cnt; ovr0 = ovr_seen;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_stim();
    idle(1);
    send_byte(8'hA5);
    settle("t1");
    want = '{8'h11, 8'h22, 8'h33};
    check_got("t1");
    check("t1 ok pulses", ok_cnt - ok0, 1);
    check("t1 overrun on last", ovr_seen - ovr0, 1);

    // 2: bad checksum, then a good frame
    err0 = err_cnt;
    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send_stim();
    settle("t2 bad");
    check("t2 err pulses", err_cnt - err0, 1);
    check("t2 err_code", err_code, 2);
    check("t2 no output", got.size(), 0);
    stim = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
    send_stim();
    settle("t2 good");
    want = '{8'h01, 8'h02};
    check_got("t2");
    check("t2 code kept after ok", err_code, 2);

    // 3: bad LEN (0 and 17), trailing bytes ignored
    err0 = err_cnt;
    stim = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33};
    send_stim();
    settle("t3 bad");
    check("t3 err pulses", err_cnt - err0, 2);
    check("t3 err_code", err_code, 1);
    stim = '{8'hA5, 8'h01, 8'h40, 8'h41};
    send_stim();
    settle("t3 good");
    want = '{8'h40};
    check_got("t3");

    // 4: timeout latency and the no-timeout edge
    stim = '{8'hA5, 8'h02, 8'h11};
    send_stim();
    model_timeout();
    k = 0;
    while (k < T + 10) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (frame_err) break;
    end
    check("t4 timeout latency", k, T + 1);
    check("t4 err_code", err_code, 3);
    settle("t4 timeout");
    ok0 = ok_cnt;
    stim = '{8'hA5, 8'h02, 8'h11};
    send_stim();
    idle(T - 2);
    send_byte(8'h22);
    send_byte(8'h35);
    settle("t4 late");
    want = '{8'h11, 8'h22};
    check_got("t4");
    check("t4 ok pulses", ok_cnt - ok0, 1);

    // 5: 16 x FF with random backpressure and bytes during drain
    rand_ready = 1;
    ovr0 = ovr_seen;
    stim = '{8'hA5, 8'h10};
    repeat (16) stim.push_back(8'hFF);
    stim.push_back(8'h00);
    send_stim();
    send_byte(8'h11);
    send_byte(8'hA5);
    send_byte(8'h02);
    settle("t5");
    repeat (16) want.push_back(8'hFF);
    check_got("t5");
    check("t5 overruns", ovr_seen - ovr0, 3);
    rand_ready = 0;
    stim = '{8'hA5, 8'h01, 8'h55, 8'h56};
    send_stim();
    settle("t5 after");
    want = '{8'h55};
    check_got("t5 after");

    // 6: noise before sync, then reset in the middle of a payload
    stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_stim();
    settle("t6 noise");
    want = '{8'h7E};
    check_got("t6");
    stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_stim();
    check("t6 busy mid frame", busy, 1);
    check("t6 code before reset", err_code, 3);
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("t6 reset outputs", {out_data, out_valid, out_last, frame_ok, frame_err,
                               err_code, overrun, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    stim = '{8'hA5, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h24};
    send_stim();
    settle("t6 after reset");
    want = '{8'h0A, 8'h0B, 8'h0C};
    check_got("t6 after reset");

    check("overrun total", ovr_seen, exp_ovr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
